// File: rtl/mips_pkg.sv
// mips_pkg: shared select codes, widths and the MEM/WB bundle for the pipelined MIPS core
package mips_pkg;
  localparam int WORD_W = 32;
  localparam int REG_AW = 5;
  typedef enum logic [1:0] {WB_ALU = 2'b00, WB_MEM = 2'b01, WB_LINK = 2'b10, WB_NONE = 2'b11} wb_sel_e;
  typedef enum logic [1:0] {LD_BYTE = 2'b00, LD_HALF = 2'b01, LD_WORD = 2'b10} ld_size_e;
  localparam logic [REG_AW-1:0] REG_ZERO = '0;
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic [1:0]        wb_sel;
    logic [1:0]        ld_size;
    logic              ld_signed;
    logic [REG_AW-1:0] writereg;
    logic [WORD_W-1:0] alu;
    logic [WORD_W-1:0] readdata;
    logic [WORD_W-1:0] pc4;
  } mem_wb_t;
endpackage

// File: rtl/mem_wb_writeback_load_extract.sv
// load_extract: big-endian byte/half/word selection with zero or sign extension
module load_extract
  import mips_pkg::*;
(
  input  logic [WORD_W-1:0] i_raw,
  input  logic [1:0]        i_off,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  output logic [WORD_W-1:0] o_data
);
  logic [4:0]  w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  // offset 0 is the most significant byte, so shift right by 24 - 8*off
  assign w_shift = 5'd24 - {i_off, 3'b000};
  assign w_byte  = 8'(i_raw >> w_shift);
  assign w_half  = i_off[1] ? i_raw[15:0] : i_raw[31:16];
  assign o_data  = (i_size == LD_BYTE) ? {{24{i_signed & w_byte[7]}}, w_byte} :
                   (i_size == LD_HALF) ? {{16{i_signed & w_half[15]}}, w_half} : i_raw;
endmodule

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB register, load extraction, writeback select, ID bypass flags and instret
module mem_wb_writeback
  import mips_pkg::*;
#(
  parameter int DW = WORD_W,
  parameter int AW = REG_AW,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          mem_valid,
  input  logic          mem_regwrite,
  input  logic [1:0]    mem_wb_sel,
  input  logic [1:0]    mem_ld_size,
  input  logic          mem_ld_signed,
  input  logic [AW-1:0] mem_writereg,
  input  logic [DW-1:0] mem_alu_result,
  input  logic [DW-1:0] mem_readdata,
  input  logic [DW-1:0] mem_pc4,
  input  logic          stall,
  input  logic          flush,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  output logic          regwrite,
  output logic [AW-1:0] writereg,
  output logic [DW-1:0] writedata,
  output logic          bypass_rs,
  output logic          bypass_rt,
  output logic [CW-1:0] instret
);
  mem_wb_t       r_q;
  mem_wb_t       w_d;
  logic [CW-1:0] r_instret;
  logic [DW-1:0] w_load;
  logic [DW-1:0] w_sel;
  logic          w_regwrite;
  always_comb begin
    w_d = r_q;
    if (flush) w_d = '0;
    else if (!stall) begin
      w_d.valid     = mem_valid;
      w_d.regwrite  = mem_regwrite;
      w_d.wb_sel    = mem_wb_sel;
      w_d.ld_size   = mem_ld_size;
      w_d.ld_signed = mem_ld_signed;
      w_d.writereg  = mem_writereg;
      w_d.alu       = mem_alu_result;
      w_d.readdata  = mem_readdata;
      w_d.pc4       = mem_pc4;
    end
  end
  // an instruction retires when it leaves WB; a stalled one is counted once, on release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= '0;
      r_instret <= '0;
    end else begin
      r_q <= w_d;
      if (r_q.valid && !stall) r_instret <= r_instret + CW'(1);
    end
  end
  load_extract u_load_extract (
    .i_raw    (r_q.readdata),
    .i_off    (r_q.alu[1:0]),
    .i_size   (r_q.ld_size),
    .i_signed (r_q.ld_signed),
    .o_data   (w_load)
  );
  assign w_regwrite = r_q.valid & r_q.regwrite & (r_q.writereg != REG_ZERO);
  assign w_sel      = (r_q.wb_sel == WB_ALU)  ? r_q.alu :
                      (r_q.wb_sel == WB_MEM)  ? w_load :
                      (r_q.wb_sel == WB_LINK) ? r_q.pc4 : '0;
  assign regwrite   = w_regwrite;
  assign writereg   = w_regwrite ? r_q.writereg : '0;
  assign writedata  = w_regwrite ? w_sel : '0;
  assign bypass_rs  = w_regwrite & (r_q.writereg == id_rs);
  assign bypass_rt  = w_regwrite & (r_q.writereg == id_rt);
  assign instret    = r_instret;
endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed scenario tasks with hand-computed expectations
module tb_mem_wb_writeback;
  logic        clk = 0;
  logic        rst_n;
  logic        mem_valid, mem_regwrite, mem_ld_signed, stall, flush;
  logic [1:0]  mem_wb_sel, mem_ld_size;
  logic [4:0]  mem_writereg, id_rs, id_rt;
  logic [31:0] mem_alu_result, mem_readdata, mem_pc4;
  logic        regwrite, bypass_rs, bypass_rt;
  logic [4:0]  writereg;
  logic [31:0] writedata, instret;
  int passed = 0;
  int total = 0;

  always #5 clk = ~clk;

  mem_wb_writeback dut (
    .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .mem_regwrite(mem_regwrite),
    .mem_wb_sel(mem_wb_sel), .mem_ld_size(mem_ld_size), .mem_ld_signed(mem_ld_signed),
    .mem_writereg(mem_writereg), .mem_alu_result(mem_alu_result), .mem_readdata(mem_readdata),
    .mem_pc4(mem_pc4), .stall(stall), .flush(flush), .id_rs(id_rs), .id_rt(id_rt),
    .regwrite(regwrite), .writereg(writereg), .writedata(writedata),
    .bypass_rs(bypass_rs), .bypass_rt(bypass_rt), .instret(instret)
  );

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel, input logic [1:0] sz,
                       input logic sg, input logic [4:0] wr, input logic [31:0] alu,
                       input logic [31:0] rd, input logic [31:0] pc4);
    mem_valid = v; mem_regwrite = rw; mem_wb_sel = sel; mem_ld_size = sz; mem_ld_signed = sg;
    mem_writereg = wr; mem_alu_result = alu; mem_readdata = rd; mem_pc4 = pc4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; stall = 0; flush = 0; id_rs = 0; id_rt = 0;
    drive(1, 1, 2'b00, 2'b10, 0, 5'd5, 32'h00001234, 32'h0, 32'h0);
    repeat (2) tick();
    total++; if (regwrite !== 1'b0) $display("FAIL reset_regwrite got %0b want 0", regwrite); else passed++;
    total++; if (writereg !== 5'd0) $display("FAIL reset_writereg got %0d want 0", writereg); else passed++;
    total++; if (writedata !== 32'h0) $display("FAIL reset_writedata got %h want 0", writedata); else passed++;
    total++; if (instret !== 32'd0) $display("FAIL reset_instret got %0d want 0", instret); else passed++;
    rst_n = 1;
    tick();
    total++; if (regwrite !== 1'b1 || writedata !== 32'h00001234) $display("FAIL post_reset_capture got %0b/%h want 1/00001234", regwrite, writedata); else passed++;
    #2 rst_n = 0;
    #1;
    total++; if (regwrite !== 1'b0 || writereg !== 5'd0 || writedata !== 32'h0) $display("FAIL async_reset got %0b/%0d/%h want 0/0/0", regwrite, writereg, writedata); else passed++;
    rst_n = 1;
    drive(0, 0, 2'b00, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    total++; if (instret !== 32'd0) $display("FAIL async_reset_instret got %0d want 0", instret); else passed++;
  endtask

  task automatic test_alu_write();
    id_rs = 5'd8; id_rt = 5'd3;
    drive(1, 1, 2'b00, 2'b10, 0, 5'd8, 32'h11110000, 32'h0, 32'h0);
    tick();
    total++; if (regwrite !== 1'b1) $display("FAIL alu_regwrite got %0b want 1", regwrite); else passed++;
    total++; if (writereg !== 5'd8) $display("FAIL alu_writereg got %0d want 8", writereg); else passed++;
    total++; if (writedata !== 32'h11110000) $display("FAIL alu_writedata got %h want 11110000", writedata); else passed++;
    total++; if (bypass_rs !== 1'b1 || bypass_rt !== 1'b0) $display("FAIL alu_bypass got rs=%0b rt=%0b want 1/0", bypass_rs, bypass_rt); else passed++;
    total++; if (instret !== 32'd0) $display("FAIL alu_instret_in_wb got %0d want 0", instret); else passed++;
    drive(0, 0, 2'b00, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    total++; if (instret !== 32'd1 || regwrite !== 1'b0) $display("FAIL alu_retire got %0d/%0b want 1/0", instret, regwrite); else passed++;
  endtask

  task automatic test_byte_loads();
    logic [31:0] want [4] = '{32'hFFFFFF80, 32'h0000007F, 32'h00000080, 32'h00000001};
    logic [31:0] offs [4] = '{32'd0, 32'd2, 32'd0, 32'd3};
    logic        sgn  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    id_rs = 5'd0; id_rt = 5'd10;
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 2'b01, 2'b00, sgn[i], 5'd10, offs[i], 32'h80FF7F01, 32'h0);
      tick();
      total++; if (writedata !== want[i]) $display("FAIL byte_load_%0d got %h want %h", i, writedata, want[i]); else passed++;
    end
    total++; if (bypass_rt !== 1'b1 || bypass_rs !== 1'b0) $display("FAIL byte_bypass got rs=%0b rt=%0b want 0/1", bypass_rs, bypass_rt); else passed++;
    drive(0, 0, 2'b00, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    total++; if (instret !== 32'd5) $display("FAIL byte_instret got %0d want 5", instret); else passed++;
  endtask

  task automatic test_half_link();
    drive(1, 1, 2'b01, 2'b01, 1, 5'd11, 32'h2, 32'h1234F00D, 32'h0);
    tick();
    total++; if (writedata !== 32'hFFFFF00D) $display("FAIL half_signed got %h want FFFFF00D", writedata); else passed++;
    drive(1, 1, 2'b01, 2'b01, 0, 5'd11, 32'h1, 32'h1234F00D, 32'h0);
    tick();
    total++; if (writedata !== 32'h00001234) $display("FAIL half_upper got %h want 00001234", writedata); else passed++;
    drive(1, 1, 2'b01, 2'b10, 1, 5'd11, 32'h3, 32'h1234F00D, 32'h0);
    tick();
    total++; if (writedata !== 32'h1234F00D) $display("FAIL word_load got %h want 1234F00D", writedata); else passed++;
    drive(1, 1, 2'b10, 2'b10, 0, 5'd31, 32'h55, 32'h0, 32'h00400008);
    tick();
    total++; if (writedata !== 32'h00400008 || writereg !== 5'd31) $display("FAIL link got %h/%0d want 00400008/31", writedata, writereg); else passed++;
    drive(1, 1, 2'b11, 2'b10, 0, 5'd4, 32'h55, 32'h66, 32'h77);
    tick();
    total++; if (writedata !== 32'h0 || regwrite !== 1'b1) $display("FAIL wb_reserved got %h/%0b want 0/1", writedata, regwrite); else passed++;
    drive(0, 0, 2'b00, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    total++; if (instret !== 32'd10) $display("FAIL half_link_instret got %0d want 10", instret); else passed++;
  endtask

  task automatic test_zero_suppress();
    id_rs = 5'd0; id_rt = 5'd0;
    drive(1, 1, 2'b00, 2'b10, 0, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0);
    tick();
    total++; if (regwrite !== 1'b0 || writereg !== 5'd0) $display("FAIL zero_regwrite got %0b/%0d want 0/0", regwrite, writereg); else passed++;
    total++; if (writedata !== 32'h0) $display("FAIL zero_writedata got %h want 0", writedata); else passed++;
    total++; if (bypass_rs !== 1'b0 || bypass_rt !== 1'b0) $display("FAIL zero_bypass got %0b/%0b want 0/0", bypass_rs, bypass_rt); else passed++;
    id_rs = 5'd7;
    drive(1, 0, 2'b00, 2'b10, 0, 5'd7, 32'hCAFEF00D, 32'h0, 32'h0);
    tick();
    total++; if (regwrite !== 1'b0 || writedata !== 32'h0 || bypass_rs !== 1'b0) $display("FAIL no_regwrite got %0b/%h/%0b want 0/0/0", regwrite, writedata, bypass_rs); else passed++;
    drive(0, 0, 2'b00, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    total++; if (instret !== 32'd12) $display("FAIL zero_instret got %0d want 12", instret); else passed++;
  endtask

  task automatic test_stall_flush();
    id_rs = 5'd9; id_rt = 5'd9;
    drive(1, 1, 2'b00, 2'b10, 0, 5'd9, 32'h00000099, 32'h0, 32'h0);
    tick();
    total++; if (regwrite !== 1'b1 || writereg !== 5'd9 || writedata !== 32'h99) $display("FAIL stall_setup got %0b/%0d/%h want 1/9/99", regwrite, writereg, writedata); else passed++;
    stall = 1;
    drive(1, 1, 2'b00, 2'b10, 0, 5'd3, 32'h00000055, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (regwrite !== 1'b1 || writereg !== 5'd9 || writedata !== 32'h99 || bypass_rt !== 1'b1) $display("FAIL stall_hold_%0d got %0b/%0d/%h want 1/9/99", i, regwrite, writereg, writedata); else passed++;
      total++; if (instret !== 32'd12) $display("FAIL stall_instret_%0d got %0d want 12", i, instret); else passed++;
    end
    flush = 1;
    tick();
    total++; if (regwrite !== 1'b0 || writedata !== 32'h0) $display("FAIL stall_flush got %0b/%h want 0/0", regwrite, writedata); else passed++;
    total++; if (instret !== 32'd12) $display("FAIL stall_flush_instret got %0d want 12", instret); else passed++;
    stall = 0; flush = 0;
    drive(0, 0, 2'b00, 2'b00, 0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    total++; if (instret !== 32'd12) $display("FAIL bubble_instret got %0d want 12", instret); else passed++;
    flush = 1;
    drive(1, 1, 2'b00, 2'b10, 0, 5'd6, 32'h00000066, 32'h0, 32'h0);
    tick();
    total++; if (regwrite !== 1'b0 || writereg !== 5'd0) $display("FAIL flush_only got %0b/%0d want 0/0", regwrite, writereg); else passed++;
    flush = 0;
    tick();
    total++; if (regwrite !== 1'b1 || writedata !== 32'h66 || instret !== 32'd12) $display("FAIL post_flush got %0b/%h/%0d want 1/66/12", regwrite, writedata, instret); else passed++;
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_byte_loads();
    test_half_link();
    test_zero_suppress();
    test_stall_flush();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
